// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2
    } fs_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, instr} buffer toward ID; entry 0 is a dedicated register so the
// presented head is always driven straight from flops.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output fetch_entry_t                 head
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  head_q;
    fetch_entry_t  tail_q [DEPTH-1];
    fetch_entry_t  ent_q  [DEPTH];
    fetch_entry_t  ent_d  [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          valid_q;

    always_comb begin
        ent_q[0] = head_q;
        for (int i = 1; i < DEPTH; i++) ent_q[i] = tail_q[i-1];
    end

    // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        if (pop && count_q != '0) begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (CW'(i + 1) < count_q) ent_d[i] = ent_q[i+1];
            count_d = count_q - 1'b1;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++)
                if (CW'(i) == count_d) ent_d[i] = push_data;
            count_d = count_d + 1'b1;
        end
        if (flush) count_d = '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '{pc: '0, instr: INSTR_NOP};
        end else begin
            count_q <= count_d;
            valid_q <= (count_d != '0);
            head_q  <= ent_d[0];
        end
    end

    // NOTE: storage behind the head is not reset; count gates its use, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        for (int i = 1; i < DEPTH; i++) tail_q[i-1] <= ent_d[i];
    end

    assign count      = count_q;
    assign head_valid = valid_q;
    assign head       = head_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/gnt/rvalid handshake
// with a single outstanding request, and buffers returned words toward ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc_i,
    input  logic        redirect_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fs_state_e     state_q, state_d;
    logic [31:0]   pc_q, fetch_pc_q;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   used;
    logic          credit, grant, resp, push;
    fetch_entry_t  head;

    always_comb begin
        used          = {1'b0, fifo_count} + (CW+1)'(outstanding_q);
        credit        = used < (CW+1)'(FIFO_DEPTH);
        imem_req_o    = (state_q == FS_REQ) && credit;
        grant         = imem_req_o && imem_gnt_i;
        resp          = (state_q == FS_WAIT) && imem_rvalid_i;
        push          = resp && !discard_q && !redirect_i;
        state_d       = state_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        case (state_q)
            FS_BOOT: state_d = FS_REQ;
            FS_REQ: begin
                if (grant) begin
                    state_d       = FS_WAIT;
                    outstanding_d = 1'b1;
                end
            end
            FS_WAIT: begin
                if (resp) begin
                    state_d       = FS_REQ;
                    outstanding_d = 1'b0;
                    discard_d     = 1'b0;
                end
            end
            default: state_d = FS_BOOT;
        endcase
        // A response already arriving with the redirect is dropped via push; only a still-pending one needs discard.
        if (redirect_i && ((state_q == FS_WAIT && !imem_rvalid_i) || grant))
            discard_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= FS_BOOT;
            pc_q          <= word_align(RESET_PC);
            fetch_pc_q    <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (redirect_i || grant) pc_q <= word_align(npc_i);
            if (grant) fetch_pc_q <= pc_q;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push),
        .push_data  ('{pc: fetch_pc_q, instr: imem_rdata_i}),
        .pop        (id_ready_i),
        .flush      (redirect_i),
        .count      (fifo_count),
        .head_valid (id_valid_o),
        .head       (head)
    );

    assign pc_o       = pc_q;
    assign id_pc_o    = head.pc;
    assign id_instr_o = head.instr;

endmodule
